// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the debug-slave command bridge: opcodes, default widths
// and the {op, dr} command entry layout.
package dbg_cmd_pkg;

  localparam int DEF_IR_WIDTH = 2;
  localparam int DEF_DR_WIDTH = 38;

  localparam logic [DEF_IR_WIDTH-1:0] OP_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_WIDTH-1:0] OP_TRACECTRL = 2'd1;
  localparam logic [DEF_IR_WIDTH-1:0] OP_BREAK     = 2'd2;
  localparam logic [DEF_IR_WIDTH-1:0] OP_TRACEMEM  = 2'd3;

  typedef struct packed {
    logic [DEF_IR_WIDTH-1:0] op;
    logic [DEF_DR_WIDTH-1:0] dr;
  } dbg_cmd_entry_t;

endpackage

// File: rtl/dbg_toggle_sync.sv
// Carries a tck-domain toggle into the clk domain and turns each flip into a
// single-cycle pulse, STAGES+1 clk after the flip.
module dbg_toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic toggle,
  output logic edge_pulse
);

  logic [STAGES-1:0] chain;
  logic              last_q;

  // The XOR is registered so downstream logic sees a clean flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain      <= '0;
      last_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      chain      <= {chain[STAGES-2:0], toggle};
      last_q     <= chain[STAGES-1];
      edge_pulse <= chain[STAGES-1] ^ last_q;
    end
  end

endmodule

// File: rtl/debug_slave_cmd_bridge.sv
// System-clock side of the JTAG debug slave: synchronised IR/DR updates, a small
// command FIFO and per-opcode action strobes. Optional macro: DBG_CMD_PARITY_EN.
module debug_slave_cmd_bridge
  import dbg_cmd_pkg::*;
#(
  parameter int IR_WIDTH    = DEF_IR_WIDTH,
  parameter int DR_WIDTH    = DEF_DR_WIDTH,
  parameter int ACTION_BIT  = 34,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [DR_WIDTH-1:0]           sr,
  input  logic                          uir_toggle,
  input  logic                          udr_toggle,
  input  logic                          cmd_ready,
  input  logic                          overflow_clr,
  output logic                          cmd_valid,
  output logic [DR_WIDTH-1:0]           jdo,
  output logic [IR_WIDTH-1:0]           cmd_op,
  output logic [2**IR_WIDTH-1:0]        take_action,
  output logic [2**IR_WIDTH-1:0]        take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          parity_err
);

  localparam int OPS = 2**IR_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  typedef struct packed {
    logic [IR_WIDTH-1:0] op;
    logic [DR_WIDTH-1:0] dr;
  } entry_t;

  logic          uir_edge;
  logic          udr_edge;
  logic [IR_WIDTH-1:0] ir_q;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          parity_bad;
  logic          push_req;
  logic          push_ok;
  logic          drop;

  dbg_toggle_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk        (clk),
    .reset      (reset),
    .toggle     (uir_toggle),
    .edge_pulse (uir_edge)
  );

  dbg_toggle_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk        (clk),
    .reset      (reset),
    .toggle     (udr_toggle),
    .edge_pulse (udr_edge)
  );

`ifdef DBG_CMD_PARITY_EN
  assign parity_bad = ^sr;
`else
  assign parity_bad = 1'b0;
`endif

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign fifo_level = wr_ptr - rd_ptr;
  assign cmd_valid  = (fifo_level != '0);
  assign full       = (fifo_level == LW'(FIFO_DEPTH));
  assign pop        = cmd_valid & cmd_ready;
  assign push_req   = udr_edge & ~parity_bad;
  assign push_ok    = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  assign head   = mem[rd_ptr[AW-1:0]];
  assign jdo    = head.dr;
  assign cmd_op = head.op;

  // A push in the same cycle as a uir edge stores the opcode still held in ir_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (uir_edge) ir_q <= ir_in;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= '{op: ir_q, dr: sr};
    end
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    for (int i = 0; i < OPS; i++) begin
      if (pop && (cmd_op == IR_WIDTH'(i))) begin
        take_action[i]    = jdo[ACTION_BIT];
        take_no_action[i] = ~jdo[ACTION_BIT];
      end
    end
  end

  // Sticky flags: a fresh event in the same cycle beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef DBG_CMD_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       parity_err <= 1'b0;
    else if (udr_edge && parity_bad) parity_err <= 1'b1;
    else if (overflow_clr)           parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_debug_slave_cmd_bridge.sv
// Scoreboard bench for debug_slave_cmd_bridge: a cycle-scheduled queue model
// predicts every output; a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_debug_slave_cmd_bridge;
  import dbg_cmd_pkg::*;

  localparam int IR_W  = 2;
  localparam int DR_W  = 38;
  localparam int ACT   = 34;
  localparam int S     = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [DR_W-1:0] sr = '0;
  logic            uir_toggle = 1'b0;
  logic            udr_toggle = 1'b0;
  logic            cmd_ready = 1'b0;
  logic            overflow_clr = 1'b0;
  logic            cmd_valid;
  logic [DR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_op;
  logic [3:0]      take_action;
  logic [3:0]      take_no_action;
  logic [2:0]      fifo_level;
  logic            overflow;
  logic            parity_err;

  debug_slave_cmd_bridge #(
    .IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .ACTION_BIT(ACT),
    .SYNC_STAGES(S), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .uir_toggle(uir_toggle), .udr_toggle(udr_toggle),
    .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
    .cmd_valid(cmd_valid), .jdo(jdo), .cmd_op(cmd_op),
    .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int              due;
    logic [DR_W-1:0] val;
  } due_t;

  due_t            udr_due[$];
  due_t            uir_due[$];
  dbg_cmd_entry_t  model_q[$];
  logic [IR_W-1:0] model_ir = '0;
  logic            model_ovf = 1'b0;
  logic            model_perr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DR_W-1:0] make_sr(input bit corrupt);
    logic [DR_W-1:0] v;
    v = DR_W'({$urandom, $urandom});
`ifdef DBG_CMD_PARITY_EN
    v[DR_W-1] = (^v[DR_W-2:0]) ^ corrupt;
`else
    if (corrupt) v[0] = ~v[0];
`endif
    return v;
  endfunction

  // Flip the requested toggles and book the cycle at which the DUT acts on them.
  task automatic apply_stimulus(input bit do_uir, input logic [IR_W-1:0] ir,
                                input bit do_udr, input logic [DR_W-1:0] s);
    if (do_uir) begin
      ir_in = ir;
      uir_toggle = ~uir_toggle;
      uir_due.push_back('{cyc + S + 2, DR_W'(ir)});
    end
    if (do_udr) begin
      sr = s;
      udr_toggle = ~udr_toggle;
      udr_due.push_back('{cyc + S + 2, s});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    check_output("rst_valid", cmd_valid, 0);
    check_output("rst_level", fifo_level, 0);
    check_output("rst_take_action", take_action, 0);
    check_output("rst_take_no_action", take_no_action, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_parity_err", parity_err, 0);
    check_output("rst_jdo", jdo, 0);
    tick(1);
    reset = 1'b0;
    if (uir_toggle) uir_due.push_back('{cyc + S + 2, DR_W'(ir_in)});
    if (udr_toggle) udr_due.push_back('{cyc + S + 2, sr});
  endtask

  // Monitor: compare against the model, then advance the model to the next posedge.
  always @(negedge clk) begin : monitor
    dbg_cmd_entry_t head;
    dbg_cmd_entry_t ent;
    due_t           d;
    logic [3:0]     exp_ta;
    logic [3:0]     exp_tna;
    bit             exp_pop;
    bit             bad;
    bit             ovf_set;
    bit             perr_set;
    int             size_before;
    if (reset) begin
      check_output("mon_rst_valid", cmd_valid, 0);
      check_output("mon_rst_strobes", {take_action, take_no_action}, 0);
      model_q.delete();
      udr_due.delete();
      uir_due.delete();
      model_ir   = '0;
      model_ovf  = 1'b0;
      model_perr = 1'b0;
    end else begin
      exp_ta  = '0;
      exp_tna = '0;
      exp_pop = (model_q.size() != 0) && cmd_ready;
      if (model_q.size() != 0) begin
        head = model_q[0];
        check_output("head_jdo", jdo, head.dr);
        check_output("head_op", cmd_op, head.op);
        if (exp_pop) begin
          if (head.dr[ACT]) exp_ta[head.op] = 1'b1;
          else              exp_tna[head.op] = 1'b1;
        end
      end
      check_output("cmd_valid", cmd_valid, model_q.size() != 0);
      check_output("fifo_level", fifo_level, model_q.size());
      check_output("take_action", take_action, exp_ta);
      check_output("take_no_action", take_no_action, exp_tna);
      check_output("overflow", overflow, model_ovf);
      check_output("parity_err", parity_err, model_perr);

      ovf_set     = 1'b0;
      perr_set    = 1'b0;
      size_before = model_q.size();
      if (exp_pop) void'(model_q.pop_front());
      while (udr_due.size() != 0 && udr_due[0].due == cyc + 1) begin
        d = udr_due.pop_front();
`ifdef DBG_CMD_PARITY_EN
        bad = ^d.val;
`else
        bad = 1'b0;
`endif
        if (bad) perr_set = 1'b1;
        else if (size_before == DEPTH && !exp_pop) ovf_set = 1'b1;
        else begin
          ent.op = model_ir;
          ent.dr = d.val;
          model_q.push_back(ent);
        end
      end
      while (uir_due.size() != 0 && uir_due[0].due == cyc + 1) begin
        d = uir_due.pop_front();
        model_ir = d.val[IR_W-1:0];
      end
      model_ovf  = ovf_set  | (model_ovf  & ~overflow_clr);
      model_perr = perr_set | (model_perr & ~overflow_clr);
    end
  end

  initial begin
    int         kind;
    int         gap;
    bit         ready_bias;
    logic [1:0] rir;
    #1;
    do_reset();
    tick(2);

    // Directed: opcode 2 with action bit set, checked for latency and a one-cycle strobe.
    apply_stimulus(1, OP_BREAK, 0, '0);
    tick(S + 3);
    cmd_ready = 1'b1;
    apply_stimulus(0, '0, 1, 38'h04_0000_0001);
    tick(S + 1);
    check_output("t1_not_yet_valid", cmd_valid, 0);
    tick(1);
    check_output("t1_valid", cmd_valid, 1);
    check_output("t1_op", cmd_op, 2);
    check_output("t1_take_action", take_action, 4'b0100);
    tick(1);
    check_output("t1_strobe_gone", take_action, 0);

    // Directed: opcode 0 with action bit clear.
    apply_stimulus(1, OP_OCIMEM, 0, '0);
    tick(S + 3);
    apply_stimulus(0, '0, 1, 38'h00_0000_0003);
    tick(S + 2);
    check_output("t2_take_no_action", take_no_action, 4'b0001);
    check_output("t2_take_action", take_action, 0);
    tick(2);

    // Overflow: five pushes with the consumer stalled.
    cmd_ready = 1'b0;
    apply_stimulus(1, OP_TRACECTRL, 0, '0);
    tick(S + 3);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, '0, 1, make_sr(0));
      tick(6);
    end
    check_output("ovf_level", fifo_level, 4);
    check_output("ovf_flag", overflow, 1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check_output("ovf_cleared", overflow, 0);

    // Full FIFO with push and pop landing on the same edge.
    apply_stimulus(0, '0, 1, make_sr(0));
    tick(S + 1);
    cmd_ready = 1'b1;
    tick(1);
    check_output("fullpp_level", fifo_level, 4);
    check_output("fullpp_overflow", overflow, 0);
    tick(8);

    // Same-cycle uir/udr: first entry keeps the old opcode.
    apply_stimulus(1, OP_TRACEMEM, 1, make_sr(0));
    tick(S + 3);
    apply_stimulus(0, '0, 1, make_sr(0));
    tick(S + 3);

    // Reset with two entries queued.
    cmd_ready = 1'b0;
    apply_stimulus(0, '0, 1, make_sr(0));
    tick(S + 3);
    apply_stimulus(0, '0, 1, make_sr(0));
    tick(S + 3);
    check_output("prerst_level", fifo_level, 2);
    do_reset();
    tick(S + 3);
    cmd_ready = 1'b1;
    tick(4);

`ifdef DBG_CMD_PARITY_EN
    apply_stimulus(0, '0, 1, make_sr(1));
    tick(S + 3);
    check_output("par_err_set", parity_err, 1);
    check_output("par_no_push", fifo_level, 0);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check_output("par_err_cleared", parity_err, 0);
`endif

    // Randomized traffic with a bursty consumer.
    for (int it = 0; it < 60; it++) begin
      kind       = $urandom_range(0, 3);
      rir        = 2'($urandom);
      ready_bias = 1'($urandom);
      apply_stimulus(kind == 1 || kind == 3, rir, kind != 1,
                     make_sr($urandom_range(0, 7) == 0));
      gap = S + 3 + $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        cmd_ready    = ready_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        overflow_clr = ($urandom_range(0, 15) == 0);
        tick(1);
      end
    end

    overflow_clr = 1'b0;
    cmd_ready = 1'b1;
    tick(S + 3 + DEPTH + 2);
    check_output("drain_valid", cmd_valid, 0);
    check_output("drain_level", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
